// File: rtl/y_sram_writer_pkg.sv
// ---------------------------------------------------------------------------
// y_sram_writer_pkg
// Shared definitions for the Y write-back stage: default data/address/index
// widths and the 3-bit state encoding of the writer FSM.
// ---------------------------------------------------------------------------
package y_sram_writer_pkg;

    localparam int Y_DATA_WIDTH = 16;
    localparam int Y_ADDR_WIDTH = 8;
    localparam int Y_IDX_WIDTH  = 6;

    typedef logic [2:0] yWrState_t;

    localparam yWrState_t ST_IDLE    = 3'd0;
    localparam yWrState_t ST_PRIME   = 3'd1;
    localparam yWrState_t ST_STREAM  = 3'd2;
    localparam yWrState_t ST_DONE    = 3'd3;
    localparam yWrState_t ST_WAITLOW = 3'd4;

endpackage

// File: rtl/y_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// y_wr_addr_gen
// Read/write index counters, end-of-vector compares and SRAM address
// formation for the Y writer.
//   clock, reset      : system clock, async active-low reset
//   clear             : synchronous clear (abort)
//   start             : latch startBase/startCount, zero both indices
//   rdStep / wrStep   : advance read / write index
//   rdAddr            : current read index into the result buffer
//   rdMore            : read index still below the element count
//   wrLast            : the write currently presented is the final one
//   sramAddr          : base + write index, modulo 2^ADDR_WIDTH
// ---------------------------------------------------------------------------
module y_wr_addr_gen
    import y_sram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = Y_ADDR_WIDTH,
    parameter int IDX_WIDTH  = Y_IDX_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startBase,
    input  logic [IDX_WIDTH:0]    startCount,
    input  logic                  rdStep,
    input  logic                  wrStep,
    output logic [IDX_WIDTH-1:0]  rdAddr,
    output logic                  rdMore,
    output logic                  wrLast,
    output logic [ADDR_WIDTH-1:0] sramAddr
);

    logic [ADDR_WIDTH-1:0] baseAddr;
    logic [IDX_WIDTH:0]    count;
    logic [IDX_WIDTH:0]    rdIdx;
    logic [IDX_WIDTH:0]    wrIdx;
    logic [IDX_WIDTH:0]    wrIdxNext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baseAddr <= '0;
            count    <= '0;
            rdIdx    <= '0;
            wrIdx    <= '0;
        end else if (clear) begin
            baseAddr <= '0;
            count    <= '0;
            rdIdx    <= '0;
            wrIdx    <= '0;
        end else if (start) begin
            baseAddr <= startBase;
            count    <= startCount;
            rdIdx    <= '0;
            wrIdx    <= '0;
        end else begin
            if (rdStep) rdIdx <= rdIdx + 1'b1;
            if (wrStep) wrIdx <= wrIdxNext;
        end
    end

    // Indices carry one extra bit so a full 2^IDX_WIDTH vector compares cleanly.
    assign wrIdxNext = wrIdx + 1'b1;
    assign rdAddr    = rdIdx[IDX_WIDTH-1:0];
    assign rdMore    = rdIdx < count;
    assign wrLast    = wrIdxNext == count;
    assign sramAddr  = baseAddr + ADDR_WIDTH'(wrIdx);

endmodule

// File: rtl/y_sram_writer.sv
// ---------------------------------------------------------------------------
// y_sram_writer
// Streams the update-Y result buffer into the Y SRAM when the sequencer
// raises in_writeYvalEnable, then returns a one-cycle done pulse.
//   clock, reset             : system clock, async active-low reset
//   soft_rst                 : synchronous abort/clear
//   in_writeYvalEnable       : level enable from the sequencer
//   in_yBaseAddr, in_yCount  : first SRAM address / element count (latched)
//   in_sramGrant             : SRAM bus accepts the presented write
//   op_resultRdEn/RdAddr     : result-buffer read port
//   in_resultRdData          : buffer data, one cycle after the strobe
//   op_ySramWe/Addr/WData    : Y SRAM write port
//   op_updateYwriteDoneFlag  : done pulse to the sequencer
//   op_busy                  : high outside IDLE
//
// state   | meaning
// IDLE    | waiting for enable
// PRIME   | first buffer read in flight
// STREAM  | presenting one element per cycle to the SRAM
// DONE    | done pulse
// WAITLOW | waiting for the sequencer to drop enable
// ---------------------------------------------------------------------------
module y_sram_writer
    import y_sram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = Y_DATA_WIDTH,
    parameter int ADDR_WIDTH = Y_ADDR_WIDTH,
    parameter int IDX_WIDTH  = Y_IDX_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_rst,
    input  logic                  in_writeYvalEnable,
    input  logic [ADDR_WIDTH-1:0] in_yBaseAddr,
    input  logic [IDX_WIDTH:0]    in_yCount,
    input  logic                  in_sramGrant,
    output logic                  op_resultRdEn,
    output logic [IDX_WIDTH-1:0]  op_resultRdAddr,
    input  logic [DATA_WIDTH-1:0] in_resultRdData,
    output logic                  op_ySramWe,
    output logic [ADDR_WIDTH-1:0] op_ySramAddr,
    output logic [DATA_WIDTH-1:0] op_ySramWData,
    output logic                  op_updateYwriteDoneFlag,
    output logic                  op_busy
);

    yWrState_t             state;
    yWrState_t             stateNext;
    logic                  dataValid;
    logic                  dataValidNext;
    logic                  start;
    logic                  rdStep;
    logic                  wrStep;
    logic                  rdEnRaw;
    logic                  rdMore;
    logic                  wrLast;
    logic                  live;
    logic                  streamWe;
    logic [IDX_WIDTH-1:0]  genRdAddr;
    logic [ADDR_WIDTH-1:0] genSramAddr;

    y_wr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) addrGen (
        .clock      (clock),
        .reset      (reset),
        .clear      (soft_rst),
        .start      (start),
        .startBase  (in_yBaseAddr),
        .startCount (in_yCount),
        .rdStep     (rdStep),
        .wrStep     (wrStep),
        .rdAddr     (genRdAddr),
        .rdMore     (rdMore),
        .wrLast     (wrLast),
        .sramAddr   (genSramAddr)
    );

    always_comb begin
        stateNext     = state;
        dataValidNext = dataValid;
        start         = 1'b0;
        rdStep        = 1'b0;
        wrStep        = 1'b0;
        rdEnRaw       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_writeYvalEnable) begin
                    start = 1'b1;
                    if (in_yCount == '0) begin
                        stateNext = ST_DONE;
                    end else begin
                        rdEnRaw   = 1'b1;
                        stateNext = ST_PRIME;
                    end
                end
            end
            ST_PRIME: begin
                rdStep        = 1'b1;
                dataValidNext = 1'b1;
                stateNext     = ST_STREAM;
            end
            ST_STREAM: begin
                // Without grant nothing moves: buffer data is held because no
                // new read strobe is issued.
                if (dataValid && in_sramGrant) begin
                    wrStep = 1'b1;
                    if (rdMore) begin
                        rdEnRaw = 1'b1;
                        rdStep  = 1'b1;
                    end else begin
                        dataValidNext = 1'b0;
                    end
                    if (wrLast) stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                stateNext = ST_WAITLOW;
            end
            ST_WAITLOW: begin
                if (!in_writeYvalEnable) stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            dataValid <= 1'b0;
        end else if (soft_rst) begin
            state     <= ST_IDLE;
            dataValid <= 1'b0;
        end else begin
            state     <= stateNext;
            dataValid <= dataValidNext;
        end
    end

    // soft_rst silences every output in the cycle it is raised, so an abort
    // never lets one more write or a done pulse slip out.
    assign live     = !soft_rst;
    assign streamWe = live && (state == ST_STREAM) && dataValid;

    assign op_resultRdEn   = live && rdEnRaw;
    assign op_resultRdAddr = (op_resultRdEn && (state == ST_STREAM)) ? genRdAddr : '0;
    assign op_ySramWe      = streamWe;
    assign op_ySramAddr    = streamWe ? genSramAddr : '0;
    assign op_ySramWData   = streamWe ? in_resultRdData : '0;

    assign op_updateYwriteDoneFlag = live && (state == ST_DONE);
    assign op_busy                 = live && (state != ST_IDLE);

endmodule

// File: tb/tb_y_sram_writer.sv
module tb_y_sram_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        soft_rst = 1'b0;
    logic        in_writeYvalEnable = 1'b0;
    logic [7:0]  in_yBaseAddr = 8'h00;
    logic [6:0]  in_yCount = 7'd0;
    logic        in_sramGrant = 1'b0;
    logic        op_resultRdEn;
    logic [5:0]  op_resultRdAddr;
    logic [15:0] in_resultRdData;
    logic        op_ySramWe;
    logic [7:0]  op_ySramAddr;
    logic [15:0] op_ySramWData;
    logic        op_updateYwriteDoneFlag;
    logic        op_busy;

    logic [15:0] mem [64];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] base;
        int         cnt;
        int         stallStart;
        int         stallLen;
        int         pat;
        int         hold;
        int         expDone;
    } vec_t;

    vec_t vecs [7];

    y_sram_writer dut (
        .clock                   (clock),
        .reset                   (reset),
        .soft_rst                (soft_rst),
        .in_writeYvalEnable      (in_writeYvalEnable),
        .in_yBaseAddr            (in_yBaseAddr),
        .in_yCount               (in_yCount),
        .in_sramGrant            (in_sramGrant),
        .op_resultRdEn           (op_resultRdEn),
        .op_resultRdAddr         (op_resultRdAddr),
        .in_resultRdData         (in_resultRdData),
        .op_ySramWe              (op_ySramWe),
        .op_ySramAddr            (op_ySramAddr),
        .op_ySramWData           (op_ySramWData),
        .op_updateYwriteDoneFlag (op_updateYwriteDoneFlag),
        .op_busy                 (op_busy)
    );

    always #5 clock = ~clock;

    // Result buffer: data for the strobed index one cycle later, held otherwise.
    always @(posedge clock or negedge reset) begin
        if (!reset) in_resultRdData <= 16'h0000;
        else if (op_resultRdEn) in_resultRdData <= mem[op_resultRdAddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fillMem(input int pat);
        for (int i = 0; i < 64; i++)
            mem[i] = (pat == 0) ? 16'(16'hA0 + i) : 16'($urandom);
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    // Expected writes: element i goes to (base+i) mod 256 with data mem[i],
    // in order; done one cycle after the last accepted write (cycle 1 when
    // count is 0); busy until the cycle after enable is dropped.
    task automatic runXfer(input logic [7:0] base, input int cnt, input int stallStart,
                           input int stallLen, input bit randGrant, input int hold,
                           output int doneCycle, output int nWrites);
        int wrIdx;
        int lastAcc;
        int doneSeen;
        int expDone;
        logic g;
        logic [7:0] ea;
        wrIdx = 0; lastAcc = -1; doneSeen = 0; doneCycle = -1; nWrites = 0;
        in_yBaseAddr = base;
        in_yCount = cnt[6:0];
        in_writeYvalEnable = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            g = randGrant ? ($urandom_range(0, 3) != 0)
                          : !(cyc >= stallStart && cyc < stallStart + stallLen);
            in_sramGrant = g;
            if (cyc == 1) begin
                in_yBaseAddr = 8'($urandom);
                in_yCount = 7'($urandom_range(0, 64));
            end
            if (doneSeen != 0 && cyc == doneCycle + 1 + hold) in_writeYvalEnable = 1'b0;
            @(negedge clock);
            if (cyc == 0) begin
                chk("startRdEn", op_resultRdEn, (cnt != 0) ? 1 : 0);
                if (cnt != 0) chk("startRdAddr", op_resultRdAddr, 0);
            end
            if (cyc > 0 && !g) chk("noRdInStall", op_resultRdEn, 0);
            if (cyc < 2 || wrIdx >= cnt) begin
                chk("weOutsideStream", op_ySramWe, 0);
            end else if (op_ySramWe) begin
                ea = base + 8'(wrIdx);
                chk("wrAddr", op_ySramAddr, ea);
                chk("wrData", op_ySramWData, mem[wrIdx]);
                if (g) begin
                    wrIdx++;
                    nWrites++;
                    lastAcc = cyc;
                end
            end
            if (op_updateYwriteDoneFlag) begin
                if (doneSeen != 0) begin
                    chk("singleDone", op_updateYwriteDoneFlag, 0);
                end else begin
                    expDone = (cnt == 0) ? 1 : lastAcc + 1;
                    chk("doneAt", cyc, expDone);
                    doneSeen = 1;
                    doneCycle = cyc;
                end
            end
            chk("busy", op_busy,
                (cyc >= 1 && (doneSeen == 0 || cyc < doneCycle + 2 + hold)) ? 1 : 0);
            @(posedge clock);
            #1;
            if (doneSeen != 0 && cyc >= doneCycle + 3 + hold) break;
        end
        if (doneSeen == 0) chk("doneTimeout", doneSeen, 1);
        in_writeYvalEnable = 1'b0;
        in_sramGrant = 1'b0;
    endtask

    initial begin
        int dc;
        int nw;
        int rc;
        logic [7:0] rb;

        vecs[0] = '{8'h10,  4, 99, 0, 0, 0,  6};
        vecs[1] = '{8'h10,  4,  4, 3, 0, 0,  9};
        vecs[2] = '{8'h00,  0, 99, 0, 0, 0,  1};
        vecs[3] = '{8'h10,  4, 99, 0, 0, 5,  6};
        vecs[4] = '{8'hFE,  3, 99, 0, 0, 0,  5};
        vecs[5] = '{8'hF0, 64, 99, 0, 1, 0, 66};
        vecs[6] = '{8'h33,  1,  2, 2, 1, 0,  5};

        #12;
        chk("rstWe", op_ySramWe, 0);
        chk("rstAddr", op_ySramAddr, 0);
        chk("rstWData", op_ySramWData, 0);
        chk("rstRdEn", op_resultRdEn, 0);
        chk("rstDone", op_updateYwriteDoneFlag, 0);
        chk("rstBusy", op_busy, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int v = 0; v < 7; v++) begin
            fillMem(vecs[v].pat);
            runXfer(vecs[v].base, vecs[v].cnt, vecs[v].stallStart, vecs[v].stallLen,
                    1'b0, vecs[v].hold, dc, nw);
            chk("vecDoneCycle", dc, vecs[v].expDone);
            chk("vecWrites", nw, vecs[v].cnt);
            repeat (2) @(posedge clock);
            #1;
        end

        // soft_rst on the second write: one element written, no done pulse.
        fillMem(0);
        in_yBaseAddr = 8'h20;
        in_yCount = 7'd5;
        in_sramGrant = 1'b1;
        in_writeYvalEnable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("srFirstWe", op_ySramWe, 1);
        chk("srFirstAddr", op_ySramAddr, 8'h20);
        chk("srFirstData", op_ySramWData, 16'hA0);
        @(posedge clock);
        #1;
        soft_rst = 1'b1;
        in_writeYvalEnable = 1'b0;
        #1;
        chk("srWe", op_ySramWe, 0);
        chk("srRdEn", op_resultRdEn, 0);
        chk("srBusy", op_busy, 0);
        @(posedge clock);
        #1;
        soft_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("srNoDone", op_updateYwriteDoneFlag, 0);
            chk("srIdle", op_busy, 0);
            chk("srNoWe", op_ySramWe, 0);
        end
        @(posedge clock);
        #1;

        // async reset pulse while in PRIME
        in_yBaseAddr = 8'h40;
        in_yCount = 7'd5;
        in_writeYvalEnable = 1'b1;
        @(posedge clock);
        #1;
        chk("primeBusy", op_busy, 1);
        #2;
        reset = 1'b0;
        in_writeYvalEnable = 1'b0;
        #1;
        chk("arBusy", op_busy, 0);
        chk("arRdEn", op_resultRdEn, 0);
        chk("arDone", op_updateYwriteDoneFlag, 0);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("arIdle", op_busy, 0);
        fillMem(1);
        runXfer(8'h40, 3, 99, 0, 1'b0, 0, dc, nw);
        chk("restartDone", dc, 5);
        chk("restartWrites", nw, 3);
        repeat (2) @(posedge clock);
        #1;

        // randomized transfers with random grant
        for (int r = 0; r < 25; r++) begin
            fillMem(1);
            rb = 8'($urandom);
            rc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 64);
            runXfer(rb, rc, 0, 0, 1'b1, $urandom_range(0, 2), dc, nw);
            chk("rndWrites", nw, rc);
            @(posedge clock);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
